alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the 8-bit combinational ALU. Accepts an op on a
//  valid/ready interface and runs it single-cycle (logic/arith) or multi-cycle (variable
//  shifts, optional shift-add multiply). Holds the result and a flag register until
//  consumed. Sits between the register file operand latches and the CPU data bus.
// PARAMETERS
//  WIDTH      8   operand/result width in bits (>=4)
//  SHAMT_W    $clog2(WIDTH)  shift-amount bits taken from i_b[SHAMT_W-1:0]
// PORTS
//  i_clk      in   1      clock, rising edge
//  i_rstn     in   1      asynchronous reset, active-low
//  i_valid    in   1      op request valid
//  o_ready    out  1      block can accept an op this cycle
//  i_op       in   4      alu_op_e opcode
//  i_a        in   WIDTH  operand A
//  i_b        in   WIDTH  operand B / shift amount
//  i_cin      in   1      carry in (ADD, SUB, NOTA)
//  i_flag_we  in   1      sampled at accept; 1 = update o_flags with this op's flags
//  o_valid    out  1      o_result valid
//  i_ready    in   1      consumer accepts result
//  o_result   out  WIDTH  registered result
//  o_flags    out  5      registered {zr,ng,co,pa,of}
//  o_busy     out  1      1 while in EXEC
// BEHAVIOUR
//  - Reset (async): state IDLE; o_result=0, o_flags=0, o_valid=0, o_busy=0, o_ready=1.
//  - Accept: i_valid & o_ready at a rising edge. o_ready = IDLE | (DONE & i_ready), so
//    back-to-back ops are allowed. i_valid while o_ready=0 is ignored (not queued).
//  - FSM: IDLE -accept,single-> DONE; IDLE -accept,multi-> EXEC; EXEC -last step-> DONE;
//    DONE -i_ready & !accept-> IDLE; DONE -i_ready & accept-> DONE or EXEC per new op.
//  - Latency (accept edge to o_valid=1): single-cycle ops 1; shifts 1+max(1,N), N=shamt;
//    MUL 1+WIDTH. In DONE, o_result/o_flags are stable until the i_ready handshake.
//  - Ops: 0 PASSA, 1 PASSB, 2 AND, 3 OR, 4 XOR, 5 ADD a+b+cin, 6 SUB a+~b+cin
//    (co=1 means no borrow), 7 ZERO, 8 NOTA ~a+cin, 9 INC a+1, A DEC a-1,
//    B SHL by N, C SHR (logical) by N, D ASR by N, E ROL by N, F MUL (macro-gated).
//  - Shifts: one bit per EXEC cycle; co = last bit shifted out; N=0 -> one EXEC cycle,
//    result=a, co=0. ROL: co = final bit rotated from MSB.
//  - MUL: unsigned shift-add, WIDTH EXEC cycles, 2*WIDTH accumulator; o_result = low half,
//    co = |high half; of = co.
//  - Flags: zr = result==0; ng = result[MSB]; pa = 1 when result has even number of 1s;
//    of = signed overflow for ADD/SUB/INC/DEC (operands' sign equal, result sign
//    differs), 0 for logic/pass ops; co = 0 for ops not defining it.
//    o_flags loads when entering DONE, only if i_flag_we was 1 at accept; else held.
//  - Width: all arithmetic is WIDTH+1 bits internally; results wrap modulo 2^WIDTH.
//  - Reset mid-EXEC aborts the op; no partial result or flag update is ever visible.
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined: op F = multi-cycle MUL as above.
//  Not defined: op F is single-cycle PASSA with co=0, of=0. No multiplier accumulator
//  or counter logic is synthesised.
// STRUCTURE
//  Package alu_pkg: alu_op_e enum (4-bit), flag index constants FLG_ZR..FLG_OF,
//  alu_state_e {IDLE, EXEC, DONE}, function is_multi_cycle(alu_op_e).
//  Sub-module alu_iter_unit: shift/rotate/MUL datapath with step counter and done pulse.
//  Top: FSM, single-cycle combinational ops, flag generation, result/flag registers.
// TESTING (WIDTH=8)
//  ADD a=7F b=01 cin=0 flag_we=1 -> result 80 after 1 cycle; flags zr0 ng1 co0 pa0 of1
//  SUB a=05 b=05 cin=1 -> result 00; zr1 ng0 co1 pa1 of0
//  SHL a=81 b=03 -> o_valid 4 cycles after accept; result 08, co0; o_busy high 3 cycles
//  MUL a=10 b=11 (MUL_EN) -> result 10 after 9 cycles, co1 of1; without macro -> 10, 1 cycle
//  Hold i_ready=0 5 cycles in DONE, pulse i_valid -> result/flags stable, op not accepted
//  Reset low during MUL EXEC -> o_valid0 o_flags00 o_ready1 immediately; next ADD 01+01 -> 02

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the handshaked sequential ALU: opcodes, flag bit positions, FSM states.
// ALU_SEQ_MUL_EN makes opcode F a multi-cycle unsigned multiply.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_PASSA = 4'h0, OP_PASSB = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3,
        OP_XOR   = 4'h4, OP_ADD   = 4'h5, OP_SUB = 4'h6, OP_ZERO = 4'h7,
        OP_NOTA  = 4'h8, OP_INC   = 4'h9, OP_DEC = 4'hA, OP_SHL  = 4'hB,
        OP_SHR   = 4'hC, OP_ASR   = 4'hD, OP_ROL = 4'hE, OP_MUL  = 4'hF
    } alu_op_e;

    // Bit positions inside o_flags = {zr,ng,co,pa,of}
    localparam int FLG_OF = 0;
    localparam int FLG_PA = 1;
    localparam int FLG_CO = 2;
    localparam int FLG_NG = 3;
    localparam int FLG_ZR = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    function automatic logic is_multi_cycle(alu_op_e op);
        case (op)
            OP_SHL, OP_SHR, OP_ASR, OP_ROL: return 1'b1;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:                         return 1'b1;
`endif
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one shift/rotate bit or one shift-add multiply step per EXEC cycle.
// The multiply accumulator exists only when ALU_SEQ_MUL_EN is defined.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic             i_step,
    input  alu_op_e          i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_co
);

    localparam int CNT_W = SHAMT_W + 1;

    alu_op_e          op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             zero_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             co_d;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = i_b[SHAMT_W-1:0];

`ifdef ALU_SEQ_MUL_EN
    // Product lives in {hi_q, acc_q}; multiplier bits drain out of acc_q's LSB.
    logic [WIDTH-1:0] hi_q, hi_d, mcand_q;
    logic [WIDTH:0]   psum;
`else
    logic unused_b;
    assign unused_b = ^i_b[WIDTH-1:SHAMT_W];
`endif

    always_comb begin
        acc_d = acc_q;
        co_d  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        hi_d  = hi_q;
        psum  = '0;
`endif
        if (!zero_q) begin
            case (op_q)
                OP_SHL: begin acc_d = {acc_q[WIDTH-2:0], 1'b0};         co_d = acc_q[WIDTH-1]; end
                OP_SHR: begin acc_d = {1'b0, acc_q[WIDTH-1:1]};         co_d = acc_q[0];       end
                OP_ASR: begin acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}; co_d = acc_q[0];     end
                OP_ROL: begin acc_d = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]}; co_d = acc_q[WIDTH-1]; end
`ifdef ALU_SEQ_MUL_EN
                OP_MUL: begin
                    psum          = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);
                    {hi_d, acc_d} = {psum, acc_q[WIDTH-1:1]};
                    co_d          = |hi_d;
                end
`endif
                default: ;
            endcase
        end
    end

    assign o_done   = i_step && (cnt_q == CNT_W'(1));
    assign o_result = acc_d;
    assign o_co     = co_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            op_q   <= OP_PASSA;
            cnt_q  <= '0;
            zero_q <= 1'b0;
            acc_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
            hi_q    <= '0;
            mcand_q <= '0;
`endif
        end else if (i_start) begin
            op_q   <= i_op;
            acc_q  <= i_a;
            // A zero shift amount still spends one EXEC cycle, leaving a untouched.
            cnt_q  <= (shamt == '0) ? CNT_W'(1) : {1'b0, shamt};
            zero_q <= (shamt == '0);
`ifdef ALU_SEQ_MUL_EN
            hi_q    <= '0;
            mcand_q <= i_a;
            if (i_op == OP_MUL) begin
                acc_q  <= i_b;
                cnt_q  <= CNT_W'(WIDTH);
                zero_q <= 1'b0;
            end
`endif
        end else if (i_step) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
            hi_q  <= hi_d;
`endif
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops, multi-cycle shifts (and MUL with
// ALU_SEQ_MUL_EN), result and flags held until the consumer takes them.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_flag_we,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [4:0]       o_flags,
    output logic             o_busy
);

    localparam int M = WIDTH - 1;

    alu_state_e       state_q, state_d;
    alu_op_e          op;
    logic             accept, start, load_sc, load_it;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       flags_q;
    logic             fwe_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res, it_res;
    logic             sc_co, sc_of, it_co, it_of, it_done;

    function automatic logic [4:0] mk_flags(logic [WIDTH-1:0] r, logic co, logic of);
        logic [4:0] f;
        f[FLG_ZR] = ~|r;
        f[FLG_NG] = r[M];
        f[FLG_CO] = co;
        f[FLG_PA] = ~^r;
        f[FLG_OF] = of;
        return f;
    endfunction

    assign op      = alu_op_e'(i_op);
    assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
    assign accept  = i_valid && o_ready;
    assign o_valid = (state_q == DONE);
    assign o_busy  = (state_q == EXEC);
    assign o_result = result_q;
    assign o_flags  = flags_q;

    // Single-cycle ops; everything arithmetic runs WIDTH+1 wide for the carry.
    always_comb begin
        sum    = '0;
        sc_res = i_a;
        sc_co  = 1'b0;
        sc_of  = 1'b0;
        case (op)
            OP_PASSB: sc_res = i_b;
            OP_AND:   sc_res = i_a & i_b;
            OP_OR:    sc_res = i_a | i_b;
            OP_XOR:   sc_res = i_a ^ i_b;
            OP_ZERO:  sc_res = '0;
            OP_ADD: begin
                sum    = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
                sc_res = sum[M:0];
                sc_co  = sum[WIDTH];
                sc_of  = (i_a[M] == i_b[M]) && (sc_res[M] != i_a[M]);
            end
            OP_SUB: begin
                sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, i_cin};
                sc_res = sum[M:0];
                sc_co  = sum[WIDTH];
                sc_of  = (i_a[M] != i_b[M]) && (sc_res[M] != i_a[M]);
            end
            OP_NOTA: begin
                sum    = {1'b0, ~i_a} + {{WIDTH{1'b0}}, i_cin};
                sc_res = sum[M:0];
                sc_co  = sum[WIDTH];
            end
            OP_INC: begin
                sum    = {1'b0, i_a} + (WIDTH+1)'(1);
                sc_res = sum[M:0];
                sc_co  = sum[WIDTH];
                sc_of  = !i_a[M] && sc_res[M];
            end
            OP_DEC: begin
                sum    = {1'b0, i_a} + {1'b0, {WIDTH{1'b1}}};
                sc_res = sum[M:0];
                sc_co  = sum[WIDTH];
                sc_of  = i_a[M] && !sc_res[M];
            end
            default: ;
        endcase
    end

    alu_iter_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_start  (start),
        .i_step   (state_q == EXEC),
        .i_op     (op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_done   (it_done),
        .o_result (it_res),
        .o_co     (it_co)
    );

`ifdef ALU_SEQ_MUL_EN
    logic mul_q;
    assign it_of = mul_q && it_co;
`else
    assign it_of = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        load_sc = 1'b0;
        load_it = 1'b0;
        if (accept) begin
            if (is_multi_cycle(op)) begin
                state_d = EXEC;
                start   = 1'b1;
            end else begin
                state_d = DONE;
                load_sc = 1'b1;
            end
        end else if (state_q == EXEC && it_done) begin
            state_d = DONE;
            load_it = 1'b1;
        end else if (state_q == DONE && i_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
            fwe_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mul_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (load_sc) begin
                result_q <= sc_res;
                if (i_flag_we) flags_q <= mk_flags(sc_res, sc_co, sc_of);
            end
            if (start) begin
                fwe_q <= i_flag_we;
`ifdef ALU_SEQ_MUL_EN
                mul_q <= (op == OP_MUL);
`endif
            end
            // Nothing from an iterative op is visible until its final step lands.
            if (load_it) begin
                result_q <= it_res;
                if (fwe_q) flags_q <= mk_flags(it_res, it_co, it_of);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8); MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [3:0] i_op = 4'h0;
    logic [7:0] i_a = 8'h00;
    logic [7:0] i_b = 8'h00;
    logic       i_cin = 1'b0;
    logic       i_flag_we = 1'b0;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic [7:0] o_result;
    logic [4:0] o_flags;
    logic       o_busy;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(8)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .i_flag_we(i_flag_we),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_flags(o_flags),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Present one op (optionally with i_ready for a back-to-back handoff), wait for o_valid.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic fwe, input logic rdy,
                          output int lat, output int busy);
        @(negedge i_clk);
        i_op = op; i_a = a; i_b = b; i_cin = cin; i_flag_we = fwe;
        i_valid = 1'b1; i_ready = rdy;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_ready = 1'b0;
        lat = 1; busy = 0;
        while (!o_valid && lat < 40) begin
            busy += int'(o_busy);
            @(posedge i_clk); #1;
            lat++;
        end
        if (!o_valid) begin
            total++; bad++;
            $display("FAIL timeout op=%h: o_valid never rose within %0d cycles", op, lat);
        end
    endtask

    task automatic consume();
        @(negedge i_clk); i_ready = 1'b1;
        @(posedge i_clk); #1; i_ready = 1'b0;
        total++;
        if ({o_valid, o_ready} !== 2'b01) begin
            bad++; $display("FAIL consume: valid/ready=%b want 01", {o_valid, o_ready});
        end
    endtask

    task automatic check_op(input string name, input int lat, input int exp_lat,
                            input logic [7:0] exp_res, input logic [4:0] exp_flg);
        total++;
        if (lat !== exp_lat || o_result !== exp_res || o_flags !== exp_flg) begin
            bad++;
            $display("FAIL %s: lat=%0d res=%h flags=%b want lat=%0d res=%h flags=%b",
                     name, lat, o_result, o_flags, exp_lat, exp_res, exp_flg);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({o_valid, o_ready, o_busy, o_result, o_flags} !== {3'b010, 8'h00, 5'h00}) begin
            bad++; $display("FAIL reset: v/r/b=%b res=%h flags=%b want 010 00 00000",
                            {o_valid, o_ready, o_busy}, o_result, o_flags);
        end
        @(negedge i_clk); i_rstn = 1'b1;
    endtask

    task automatic test_arith();
        int lat, busy;
        run_op(4'h5, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, lat, busy);
        check_op("add_7f_01", lat, 1, 8'h80, 5'b01001); consume();
        run_op(4'h6, 8'h05, 8'h05, 1'b1, 1'b1, 1'b0, lat, busy);
        check_op("sub_05_05", lat, 1, 8'h00, 5'b10110); consume();
        run_op(4'h9, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, lat, busy);
        check_op("inc_ff", lat, 1, 8'h00, 5'b10110); consume();
        run_op(4'hA, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, lat, busy);
        check_op("dec_80", lat, 1, 8'h7F, 5'b00101); consume();
    endtask

    task automatic test_flag_we();
        int lat, busy;
        // Flags must keep the DEC result from the previous op.
        run_op(4'h4, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, lat, busy);
        check_op("xor_no_fwe", lat, 1, 8'hCC, 5'b00101); consume();
    endtask

    task automatic test_shift();
        int lat, busy;
        run_op(4'hB, 8'h81, 8'h03, 1'b0, 1'b1, 1'b0, lat, busy);
        check_op("shl_81_3", lat, 4, 8'h08, 5'b00000);
        total++;
        if (busy !== 3) begin bad++; $display("FAIL shl_busy: busy=%0d want 3", busy); end
        consume();
        run_op(4'hE, 8'h81, 8'h01, 1'b0, 1'b1, 1'b0, lat, busy);
        check_op("rol_81_1", lat, 2, 8'h03, 5'b00110); consume();
        run_op(4'hD, 8'h80, 8'h02, 1'b0, 1'b1, 1'b0, lat, busy);
        check_op("asr_80_2", lat, 3, 8'hE0, 5'b01000); consume();
        run_op(4'hE, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, lat, busy);
        check_op("rol_a5_0", lat, 2, 8'hA5, 5'b01010); consume();
    endtask

    task automatic test_mul();
        int lat, busy;
        run_op(4'hF, 8'h10, 8'h11, 1'b0, 1'b1, 1'b0, lat, busy);
`ifdef ALU_SEQ_MUL_EN
        check_op("mul_10_11", lat, 9, 8'h10, 5'b00101);
`else
        check_op("opf_passa", lat, 1, 8'h10, 5'b00000);
`endif
        consume();
    endtask

    task automatic test_hold();
        int lat, busy;
        run_op(4'h5, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, lat, busy);
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            i_op = 4'h7; i_flag_we = 1'b1; i_valid = (c == 2);
            @(posedge i_clk); #1; i_valid = 1'b0;
            total++;
            if ({o_valid, o_ready, o_result, o_flags} !== {2'b10, 8'h80, 5'b01001}) begin
                bad++; $display("FAIL hold_c%0d: v/r=%b res=%h flags=%b want 10 80 01001",
                                c, {o_valid, o_ready}, o_result, o_flags);
            end
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat, busy;
        run_op(4'h6, 8'h05, 8'h05, 1'b1, 1'b1, 1'b0, lat, busy);
        run_op(4'h5, 8'h01, 8'h02, 1'b0, 1'b1, 1'b1, lat, busy);
        check_op("b2b_add", lat, 1, 8'h03, 5'b00010);
        run_op(4'hC, 8'h03, 8'h01, 1'b0, 1'b1, 1'b1, lat, busy);
        check_op("b2b_shr", lat, 2, 8'h01, 5'b00100);
        consume();
    endtask

    task automatic test_reset_mid_exec();
        int lat, busy;
        @(negedge i_clk);
`ifdef ALU_SEQ_MUL_EN
        i_op = 4'hF; i_a = 8'h10; i_b = 8'h11;
`else
        i_op = 4'hC; i_a = 8'h80; i_b = 8'h07;
`endif
        i_flag_we = 1'b1; i_valid = 1'b1;
        @(posedge i_clk); #1; i_valid = 1'b0;
        @(posedge i_clk); #1;
        total++;
        if (o_busy !== 1'b1) begin bad++; $display("FAIL mid_busy: busy=%b want 1", o_busy); end
        i_rstn = 1'b0; #1;
        total++;
        if ({o_valid, o_ready, o_busy, o_result, o_flags} !== {3'b010, 8'h00, 5'h00}) begin
            bad++; $display("FAIL mid_reset: v/r/b=%b res=%h flags=%b want 010 00 00000",
                            {o_valid, o_ready, o_busy}, o_result, o_flags);
        end
        @(negedge i_clk); i_rstn = 1'b1;
        run_op(4'h5, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, lat, busy);
        check_op("post_reset_add", lat, 1, 8'h02, 5'b00000);
        consume();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_flag_we();
        test_shift();
        test_mul();
        test_hold();
        test_back_to_back();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
